// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control core: fetches over a valid handshake, drives an
// external combinational Hack ALU, and accesses data memory (M) via req/resp.
module hack_cpu_ctrl #(
  parameter logic [14:0] RESET_PC = 15'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        instr_req,
  output logic [14:0] instr_addr,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata,
  input  logic        mem_wack,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  output logic [14:0] pc
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;

  logic [1:0]  state_r;
  logic [14:0] pc_r;
  logic [15:0] a_r;
  logic [15:0] d_r;
  logic [15:0] ir_r;
  logic [15:0] mreg_r;
  logic        jump_s;
  logic [14:0] pc_inc_s;

  function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

  assign pc         = pc_r;
  assign instr_addr = pc_r;
  assign alu_x      = d_r;
  assign {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_r[11:6];

  // ALU y operand selection and jump evaluation for the current instruction
  always_comb begin
    alu_y    = a_r;
    jump_s   = 1'b0;
    pc_inc_s = pc_r + 15'd1;
    if (ir_r[12]) begin
      alu_y = mreg_r;
    end else begin
      alu_y = a_r;
    end
    jump_s = jump_taken(ir_r[2:0], alu_zr, alu_ng);
  end

  // Control state machine, architectural registers and registered requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_FETCH;
      pc_r      <= RESET_PC;
      a_r       <= 16'd0;
      d_r       <= 16'd0;
      ir_r      <= 16'd0;
      mreg_r    <= 16'd0;
      instr_req <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 15'd0;
      mem_wdata <= 16'd0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (!instr_req) begin
            instr_req <= 1'b1;
          end else if (instr_valid) begin
            ir_r      <= instr;
            instr_req <= 1'b0;
            if (instr[15] && instr[12]) begin
              state_r  <= ST_LOAD;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= a_r[14:0];
            end else begin
              state_r <= ST_EXEC;
            end
          end
        end
        ST_LOAD: begin
          if (mem_rvalid) begin
            mreg_r  <= mem_rdata;
            mem_req <= 1'b0;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!ir_r[15]) begin
            a_r       <= {1'b0, ir_r[14:0]};
            pc_r      <= pc_inc_s;
            instr_req <= 1'b1;
            state_r   <= ST_FETCH;
          end else begin
            if (ir_r[5]) a_r <= alu_out;
            if (ir_r[4]) d_r <= alu_out;
            // Jump target and store address both use A as it was before this write
            pc_r <= jump_s ? a_r[14:0] : pc_inc_s;
            if (ir_r[3]) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= a_r[14:0];
              mem_wdata <= alu_out;
              state_r   <= ST_STORE;
            end else begin
              instr_req <= 1'b1;
              state_r   <= ST_FETCH;
            end
          end
        end
        ST_STORE: begin
          if (mem_wack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            instr_req <= 1'b1;
            state_r   <= ST_FETCH;
          end
        end
        default: begin
          state_r   <= ST_FETCH;
          instr_req <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Self-checking bench for hack_cpu_ctrl: instruction-level reference model,
// directed program followed by randomized instructions and response delays.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_valid;
  logic [15:0] instr;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rvalid;
  logic [15:0] mem_rdata;
  logic        mem_wack;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] pc;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.RESET_PC(15'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_valid(instr_valid), .instr(instr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_wack(mem_wack),
    .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny), .alu_f(alu_f), .alu_no(alu_no),
    .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng), .pc(pc)
  );

  // Hack ALU semantics: returns {ng, zr, out}
  function automatic logic [17:0] hack_alu(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'd0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'd0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? (xx + yy) : (xx & yy);
    o  = c[0] ? ~o : o;
    return {o[15], (o == 16'd0), o};
  endfunction

  always_comb {alu_ng, alu_zr, alu_out} = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [14:0] v;
    if ($urandom_range(0, 9) < 4) begin
      if ($urandom_range(0, 3) == 0) v = 15'h7FF0 + 15'($urandom_range(0, 15));
      else v = 15'($urandom_range(0, 63));
      return {1'b0, v};
    end
    return {1'b1, 2'($urandom), 1'($urandom), 6'($urandom), 3'($urandom), 3'($urandom)};
  endfunction

  logic [15:0] dmem [0:32767];
  logic [15:0] dir_prog [21];
  logic [14:0] dir_pc [21];

  // Reference state: instruction-level view of the CPU
  logic [14:0] m_pc;
  logic [15:0] m_a, m_d, m_m, cur_ir, y, word, old_a;
  logic [14:0] st_addr;
  logic [15:0] st_data;
  logic [17:0] r;
  int          exp_st;   // 0 fetch, 1 load, 2 exec, 3 store
  int          issued;
  bit          reset_done;
  bit          jmp;

  initial begin
    dir_prog = '{16'h0005, 16'hEC10, 16'h0064, 16'hFC10, 16'hE7C8, 16'h0003, 16'hEC10,
                 16'h000A, 16'hE301, 16'hEA87, 16'h0000, 16'hEC10, 16'h000A, 16'hE301,
                 16'h001E, 16'hEC10, 16'h0014, 16'hE327, 16'h7FFF, 16'hEA87, 16'hEC10};
    dir_pc   = '{15'd1, 15'd2, 15'd3, 15'd4, 15'd5, 15'd6, 15'd7, 15'd8, 15'd10, 15'd10,
                 15'd11, 15'd12, 15'd13, 15'd14, 15'd15, 15'd16, 15'd17, 15'd20, 15'd21,
                 15'h7FFF, 15'd0};
    for (int i = 0; i < 32768; i++) dmem[i] = 16'($urandom);
    dmem[100] = 16'd7;

    rst_n = 1'b0; instr_valid = 1'b0; instr = 16'd0;
    mem_rvalid = 1'b0; mem_rdata = 16'd0; mem_wack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr_req", 32'(instr_req), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_d", 32'(alu_x), 32'd0);
    rst_n = 1'b1;
    m_pc = 15'd0; m_a = 16'd0; m_d = 16'd0; m_m = 16'd0;
    st_addr = 15'd0; st_data = 16'd0; cur_ir = 16'd0;
    exp_st = 0; issued = 0; reset_done = 1'b0;

    for (int cyc = 0; cyc < 30000 && issued < 400; cyc++) begin
      @(negedge clk);
      instr_valid = 1'b0; mem_rvalid = 1'b0; mem_wack = 1'b0;
      instr = 16'($urandom);
      chk("pc", 32'(pc), 32'(m_pc));
      if (exp_st != 0) chk("instr_req_idle", 32'(instr_req), 32'd0);
      case (exp_st)
        0: begin
          chk("fetch_req", 32'(instr_req), 32'd1);
          chk("fetch_addr", 32'(instr_addr), 32'(m_pc));
          chk("fetch_mem_req", 32'(mem_req), 32'd0);
          if (issued < 21 || $urandom_range(0, 9) < 6) begin
            word = (issued < 21) ? dir_prog[issued] : rand_instr();
            if (issued >= 1 && issued <= 21) chk("pin_pc", 32'(pc), 32'(dir_pc[issued-1]));
            instr_valid = 1'b1; instr = word; cur_ir = word; issued++;
            exp_st = (word[15] && word[12]) ? 1 : 2;
          end else begin
            mem_rvalid = 1'($urandom); mem_wack = 1'($urandom);
          end
        end
        1: begin
          if (!reset_done && issued >= 150) begin
            chk("load_req_pre_rst", 32'(mem_req), 32'd1);
            rst_n = 1'b0;
            #1;
            chk("rst_async_mem_req", 32'(mem_req), 32'd0);
            chk("rst_async_pc", 32'(pc), 32'd0);
            chk("rst_async_d", 32'(alu_x), 32'd0);
            @(negedge clk);
            mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
            @(negedge clk);
            rst_n = 1'b1;
            m_pc = 15'd0; m_a = 16'd0; m_d = 16'd0; m_m = 16'd0;
            exp_st = 0; reset_done = 1'b1;
          end else begin
            chk("load_req", 32'(mem_req), 32'd1);
            chk("load_we", 32'(mem_we), 32'd0);
            chk("load_addr", 32'(mem_addr), 32'(m_a[14:0]));
            if (issued <= 21 || $urandom_range(0, 9) < 5) begin
              mem_rvalid = 1'b1; mem_rdata = dmem[m_a[14:0]];
              m_m = mem_rdata; exp_st = 2;
            end else begin
              mem_wack = 1'($urandom);
            end
          end
        end
        2: begin
          chk("exec_mem_req", 32'(mem_req), 32'd0);
          y = cur_ir[12] ? m_m : m_a;
          if (cur_ir[15]) begin
            chk("alu_x", 32'(alu_x), 32'(m_d));
            chk("alu_y", 32'(alu_y), 32'(y));
            chk("alu_ctrl", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'(cur_ir[11:6]));
          end
          if (issued == 2) chk("dir_ctrl_d_eq_a", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'h30);
          if (issued == 5) chk("dir_d_before_store", 32'(alu_x), 32'd7);
          mem_rvalid = 1'($urandom); mem_wack = 1'($urandom);
          if (!cur_ir[15]) begin
            m_a = {1'b0, cur_ir[14:0]};
            m_pc = m_pc + 15'd1;
            exp_st = 0;
          end else begin
            r = hack_alu(m_d, y, cur_ir[11:6]);
            jmp = (cur_ir[2] && r[17]) || (cur_ir[1] && r[16]) || (cur_ir[0] && !r[17] && !r[16]);
            old_a = m_a;
            if (cur_ir[5]) m_a = r[15:0];
            if (cur_ir[4]) m_d = r[15:0];
            m_pc = jmp ? old_a[14:0] : (m_pc + 15'd1);
            if (cur_ir[3]) begin
              st_addr = old_a[14:0]; st_data = r[15:0]; exp_st = 3;
            end else begin
              exp_st = 0;
            end
          end
        end
        default: begin
          chk("store_req", 32'(mem_req), 32'd1);
          chk("store_we", 32'(mem_we), 32'd1);
          chk("store_addr", 32'(mem_addr), 32'(st_addr));
          chk("store_wdata", 32'(mem_wdata), 32'(st_data));
          if (issued == 5) begin
            chk("dir_store_addr", 32'(mem_addr), 32'd100);
            chk("dir_store_wdata", 32'(mem_wdata), 32'd8);
          end
          if (issued <= 21 || $urandom_range(0, 9) < 5) begin
            mem_wack = 1'b1; dmem[st_addr] = st_data; exp_st = 0;
          end else begin
            mem_rvalid = 1'($urandom);
          end
        end
      endcase
    end
    if (issued < 400) chk("progress_issued", 32'(issued), 32'd400);
    chk("reset_in_load_seen", 32'(reset_done), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
